instruction_cache: RTL and testbench

Direct-mapped, read-only instruction cache that sits directly upstream of the IF/ID pipeline register. It takes the PC-register output as its fetch address and returns the 32-bit instruction that the IF/ID register latches. On a miss it stalls the front end with BUSYWAIT and refills a 128-bit block from instruction memory over a request/busywait handshake.

---
 rtl/instruction_cache_if.sv | 10 +
 rtl/instruction_cache.sv | 91 +++++++++
 tb/tb_instruction_cache.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/instruction_cache_if.sv
// Refill bus between the instruction cache and instruction memory.
interface instruction_cache_if;
  logic [27:0]  mem_address;
  logic         mem_read;
  logic [127:0] mem_readdata;
  logic         mem_busywait;

  modport master (output mem_address, mem_read, input mem_readdata, mem_busywait);
  modport slave  (input mem_address, mem_read, output mem_readdata, mem_busywait);
endinterface

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache feeding the IF/ID register.
// On a miss it stalls the front end and refills a 128-bit block over the memory interface.
module instruction_cache #(
  parameter int          INDEX_BITS = 3,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [31:0]          ADDRESS,
  input  logic                 FLUSH,
  output logic [31:0]          INSTRUCTION,
  output logic                 BUSYWAIT,
  instruction_cache_if.master  mem
);
  localparam int NBLK  = 1 << INDEX_BITS;
  localparam int TAG_W = 28 - INDEX_BITS;

  typedef enum logic [1:0] {IDLE, MEM_READ, UPDATE} state_t;

  state_t                  state_q;
  logic [NBLK-1:0]         valid_q;
  logic [127:0]            data_q [NBLK];
  logic [TAG_W-1:0]        tag_q  [NBLK];
  logic [27:0]             maddr_q;
  logic                    mrd_q;

  logic [INDEX_BITS-1:0]   idx;
  logic [TAG_W-1:0]        tag;
  logic [1:0]              off;
  logic [INDEX_BITS-1:0]   fill_idx;
  logic [TAG_W-1:0]        fill_tag;
  logic                    hit;
  logic                    fill;
  logic                    unused_addr;

  assign idx         = ADDRESS[3+INDEX_BITS:4];
  assign tag         = ADDRESS[31:4+INDEX_BITS];
  assign off         = ADDRESS[3:2];
  assign unused_addr = ^ADDRESS[1:0];

  // Refill target comes from the latched block address, never the live ADDRESS.
  assign fill_idx = maddr_q[INDEX_BITS-1:0];
  assign fill_tag = maddr_q[27:INDEX_BITS];
  assign fill     = (state_q == MEM_READ) && !mem.mem_busywait && !RESET;

  assign hit         = (state_q == IDLE) && valid_q[idx] && (tag_q[idx] == tag);
  assign INSTRUCTION = hit ? data_q[idx][{off, 5'b0} +: 32] : NOP_INSTR;
  assign BUSYWAIT    = !hit || FLUSH;

  assign mem.mem_address = maddr_q;
  assign mem.mem_read    = mrd_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      valid_q <= '0;
      mrd_q   <= 1'b0;
      maddr_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // Flush takes priority; a pending miss is picked up on the next cycle.
          if (FLUSH) begin
            valid_q <= '0;
          end else if (!hit) begin
            maddr_q <= ADDRESS[31:4];
            mrd_q   <= 1'b1;
            state_q <= MEM_READ;
          end
        end
        MEM_READ: begin
          if (!mem.mem_busywait) begin
            valid_q[fill_idx] <= 1'b1;
            mrd_q             <= 1'b0;
            state_q           <= UPDATE;
          end
        end
        UPDATE:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Data and tag storage carry no reset; the valid bits alone qualify them.
  always_ff @(posedge CLK) begin
    if (fill) begin
      data_q[fill_idx] <= mem.mem_readdata;
      tag_q[fill_idx]  <= fill_tag;
    end
  end
endmodule

// File: tb/tb_instruction_cache.sv
// Randomized self-checking bench for instruction_cache against a block-level cache model.
module tb_instruction_cache;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        FLUSH = 1'b0;
  logic [31:0] ADDRESS = 32'h0;
  logic [31:0] INSTRUCTION;
  logic        BUSYWAIT;

  instruction_cache_if mif();

  instruction_cache dut (
    .CLK(CLK), .RESET(RESET), .ADDRESS(ADDRESS), .FLUSH(FLUSH),
    .INSTRUCTION(INSTRUCTION), .BUSYWAIT(BUSYWAIT), .mem(mif)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // Model: which memory block each cache slot holds, plus refill countdowns.
  logic        mvalid [8];
  logic [27:0] mblk   [8];
  logic [27:0] pend = 28'h0;
  int          rd_left = 0;
  logic        upd = 1'b0;
  logic        known = 1'b0;
  int          force_lat = -1;

  logic        obs_busy, obs_rd;
  logic [31:0] obs_ins;
  logic [27:0] obs_maddr;

  function automatic logic [31:0] mem_word(input logic [27:0] blk, input logic [1:0] off);
    if (blk == 28'h0) begin
      case (off)
        2'd0:    return 32'h0010_0093;
        2'd1:    return 32'h0020_0113;
        2'd2:    return 32'h0030_0193;
        default: return 32'h00C0_006F;
      endcase
    end
    return {blk[21:0] ^ 22'h15A5A5, off, 8'h17};
  endfunction

  function automatic logic [127:0] mem_block(input logic [27:0] blk);
    return {mem_word(blk, 2'd3), mem_word(blk, 2'd2), mem_word(blk, 2'd1), mem_word(blk, 2'd0)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic step(input logic [31:0] a, input logic fl, input logic rs);
    logic [2:0]  i;
    logic        hit, eb, er;
    logic [31:0] ei;
    @(negedge CLK);
    ADDRESS = a; FLUSH = fl; RESET = rs;
    if (rd_left > 0) begin
      mif.mem_busywait = (rd_left > 1);
      mif.mem_readdata = (rd_left > 1) ? {$urandom, $urandom, $urandom, $urandom} : mem_block(pend);
    end else begin
      mif.mem_busywait = 1'($urandom_range(0, 1));
      mif.mem_readdata = {$urandom, $urandom, $urandom, $urandom};
    end
    #1;
    obs_busy = BUSYWAIT; obs_ins = INSTRUCTION; obs_rd = mif.mem_read; obs_maddr = mif.mem_address;
    i = a[6:4];
    if (rd_left == 0 && !upd) begin
      hit = mvalid[i] && (mblk[i] == a[31:4]);
      eb  = !hit || fl;
      ei  = hit ? mem_word(a[31:4], a[3:2]) : NOP;
      er  = 1'b0;
    end else begin
      hit = 1'b0; eb = 1'b1; ei = NOP; er = (rd_left > 0);
    end
    if (known) begin
      chk("busywait",    {31'b0, obs_busy}, {31'b0, eb});
      chk("instruction", obs_ins, ei);
      chk("mem_read",    {31'b0, obs_rd}, {31'b0, er});
      chk("mem_address", {4'b0, obs_maddr}, {4'b0, pend});
    end
    if (rs) begin
      for (int k = 0; k < 8; k++) mvalid[k] = 1'b0;
      rd_left = 0; upd = 1'b0; pend = 28'h0; known = 1'b1;
    end else if (rd_left > 0) begin
      if (rd_left == 1) begin
        mvalid[pend[2:0]] = 1'b1;
        mblk[pend[2:0]]   = pend;
        upd = 1'b1;
      end
      rd_left--;
    end else if (upd) begin
      upd = 1'b0;
    end else if (fl) begin
      for (int k = 0; k < 8; k++) mvalid[k] = 1'b0;
    end else if (!hit) begin
      pend    = a[31:4];
      rd_left = ((force_lat >= 0) ? force_lat : int'($urandom_range(0, 3))) + 1;
    end
  endtask

  int nbusy, nrd;
  logic [27:0] seen_addr;

  initial begin
    for (int k = 0; k < 8; k++) begin mvalid[k] = 1'b0; mblk[k] = 28'h0; end
    mif.mem_busywait = 1'b1;
    mif.mem_readdata = '0;

    // Reset, then cold miss on 0x0 with 4 busy memory cycles.
    step(32'h0, 1'b0, 1'b1);
    step(32'h0, 1'b0, 1'b1);
    force_lat = 4;
    nbusy = 0; nrd = 0;
    for (int c = 0; c < 7; c++) begin
      step(32'h0, 1'b0, 1'b0);
      if (obs_busy) nbusy++;
      if (obs_rd && obs_maddr == 28'h0) nrd++;
    end
    chk("s1_busy_cycles", nbusy, 7);
    chk("s1_read_cycles", nrd, 5);
    step(32'h0, 1'b0, 1'b0);
    chk("s1_instr", obs_ins, 32'h0010_0093);
    chk("s1_busy_low", {31'b0, obs_busy}, 32'h0);

    // Sequential hits in the same block.
    step(32'h4, 1'b0, 1'b0); chk("s2_w1", obs_ins, 32'h0020_0113);
    step(32'h8, 1'b0, 1'b0); chk("s2_w2", obs_ins, 32'h0030_0193);
    step(32'hC, 1'b0, 1'b0); chk("s2_w3", obs_ins, 32'h00C0_006F);
    chk("s2_no_stall", {31'b0, obs_busy | obs_rd}, 32'h0);

    // Conflict miss at index 0, zero-latency memory.
    force_lat = 0;
    nbusy = 0; seen_addr = 28'hFFFFFFF;
    for (int c = 0; c < 4; c++) begin
      step(32'h80, 1'b0, 1'b0);
      if (obs_busy) nbusy++;
      if (obs_rd) seen_addr = obs_maddr;
    end
    chk("s3_busy_cycles", nbusy, 3);
    chk("s3_mem_address", {4'b0, seen_addr}, 32'h8);
    step(32'h0, 1'b0, 1'b0); chk("s3_remiss", {31'b0, obs_busy}, 32'h1);
    repeat (3) step(32'h0, 1'b0, 1'b0);

    // Reset in the second read cycle aborts the refill.
    step(32'h80, 1'b0, 1'b0);
    force_lat = 4;
    step(32'h80, 1'b0, 1'b0);
    step(32'h0, 1'b0, 1'b0);
    force_lat = 4;
    step(32'h0, 1'b0, 1'b0);
    step(32'h0, 1'b0, 1'b1);
    step(32'h0, 1'b0, 1'b0);
    chk("s4_read_dropped", {31'b0, obs_rd}, 32'h0);
    chk("s4_miss_after_reset", {31'b0, obs_busy}, 32'h1);
    step(32'h0, 1'b0, 1'b0);
    chk("s4_fresh_refill", {31'b0, obs_rd}, 32'h1);
    repeat (6) step(32'h0, 1'b0, 1'b0);
    chk("s4_refilled", obs_ins, 32'h0010_0093);

    // Flush pulse, then flush coinciding with a miss.
    force_lat = 0;
    step(32'h0, 1'b1, 1'b0); chk("s5_flush_busy", {31'b0, obs_busy}, 32'h1);
    step(32'h0, 1'b0, 1'b0); chk("s5_miss_after_flush", {31'b0, obs_busy}, 32'h1);
    repeat (3) step(32'h0, 1'b0, 1'b0);
    step(32'h80, 1'b1, 1'b0); chk("s5_flush_miss_no_rd", {31'b0, obs_rd}, 32'h0);
    step(32'h80, 1'b0, 1'b0); chk("s5_miss_next_no_rd", {31'b0, obs_rd}, 32'h0);
    step(32'h80, 1'b0, 1'b0); chk("s5_rd_starts", {31'b0, obs_rd}, 32'h1);
    repeat (3) step(32'h80, 1'b0, 1'b0);

    // Address moves during a refill: the latched block is still filled.
    force_lat = 2;
    step(32'h0, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      step(32'h40, 1'b0, 1'b0);
      chk("s6_addr_held", {4'b0, obs_maddr}, 32'h0);
    end
    step(32'h40, 1'b0, 1'b0);
    step(32'h40, 1'b0, 1'b0); chk("s6_miss_40", {31'b0, obs_busy}, 32'h1);
    step(32'h40, 1'b0, 1'b0); chk("s6_maddr_4", {4'b0, obs_maddr}, 32'h4);
    repeat (4) step(32'h40, 1'b0, 1'b0);
    step(32'h0, 1'b0, 1'b0); chk("s6_index0_filled", obs_ins, 32'h0010_0093);

    // Random traffic over a few tags per index, with sparse flushes and resets.
    force_lat = -1;
    for (int c = 0; c < 600; c++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 3) << 7) | ($urandom_range(0, 7) << 4) |
          ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      step(a, ($urandom_range(0, 99) < 4), ($urandom_range(0, 99) < 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
